// File: rtl/isp_csc_inv.sv
// rtl/isp_csc_inv.sv - YCbCr444 to RGB888 inverse colour-space converter, 3-stage pipeline
// Optional: ISP_CSC_INV_STUDIO_RANGE_EN selects limited-range (16-235/240) input equations.
module isp_csc_inv #(
  parameter int DW  = 8,
  parameter int LAT = 3
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          in_vsync,
  input  logic          in_href,
  input  logic [DW-1:0] in_y,
  input  logic [DW-1:0] in_u,
  input  logic [DW-1:0] in_v,
  output logic          out_vsync,
  output logic          out_href,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_g,
  output logic [DW-1:0] out_b
);

`ifdef ISP_CSC_INV_STUDIO_RANGE_EN
  localparam logic signed [19:0] K_Y  = 20'sd298;
  localparam logic signed [19:0] K_RV = 20'sd409;
  localparam logic signed [19:0] K_GU = 20'sd100;
  localparam logic signed [19:0] K_GV = 20'sd208;
  localparam logic signed [19:0] K_BU = 20'sd516;
  logic signed [8:0]  y1;
  logic signed [19:0] y1_x;
`else
  localparam logic signed [19:0] K_RV = 20'sd359;
  localparam logic signed [19:0] K_GU = 20'sd88;
  localparam logic signed [19:0] K_GV = 20'sd183;
  localparam logic signed [19:0] K_BU = 20'sd454;
  logic [16:0] y1;
`endif

  logic [LAT-1:0]     vs_d, hr_d;
  logic signed [8:0]  cb1, cr1;
  logic signed [19:0] cb1_x, cr1_x;
  logic signed [19:0] y2, p_rv, p_gu, p_gv, p_bu;
  logic signed [19:0] s_r, s_g, s_b;

  assign cb1_x = {{11{cb1[8]}}, cb1};
  assign cr1_x = {{11{cr1[8]}}, cr1};
`ifdef ISP_CSC_INV_STUDIO_RANGE_EN
  assign y1_x  = {{11{y1[8]}}, y1};
`endif

  assign s_r = y2 + p_rv + 20'sd128;
  assign s_g = y2 - p_gu - p_gv + 20'sd128;
  assign s_b = y2 + p_bu + 20'sd128;

  // Floor-shift by 8, then saturate to the 0..255 output range.
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [11:0] q;
    q = 12'(s >>> 8);
    if (q < 12'sd0)
      return 8'd0;
    else if (q > 12'sd255)
      return 8'd255;
    else
      return q[7:0];
  endfunction

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d  <= '0;
      hr_d  <= '0;
      cb1   <= '0;
      cr1   <= '0;
      y1    <= '0;
      y2    <= '0;
      p_rv  <= '0;
      p_gu  <= '0;
      p_gv  <= '0;
      p_bu  <= '0;
      out_r <= '0;
      out_g <= '0;
      out_b <= '0;
    end else begin
      vs_d <= {vs_d[LAT-2:0], in_vsync};
      hr_d <= {hr_d[LAT-2:0], in_href};

      cb1 <= 9'({1'b0, in_u}) - 9'd128;
      cr1 <= 9'({1'b0, in_v}) - 9'd128;
`ifdef ISP_CSC_INV_STUDIO_RANGE_EN
      y1  <= 9'({1'b0, in_y}) - 9'd16;
      y2  <= y1_x * K_Y;
`else
      y1  <= {in_y, 8'b0};
      y2  <= {3'b000, y1};
`endif

      p_rv <= cr1_x * K_RV;
      p_gu <= cb1_x * K_GU;
      p_gv <= cr1_x * K_GV;
      p_bu <= cb1_x * K_BU;

      // hr_d[LAT-2] becomes out_href on this same edge, so blanking is black.
      if (hr_d[LAT-2]) begin
        out_r <= clamp8(s_r);
        out_g <= clamp8(s_g);
        out_b <= clamp8(s_b);
      end else begin
        out_r <= '0;
        out_g <= '0;
        out_b <= '0;
      end
    end
  end

  assign out_vsync = vs_d[LAT-1];
  assign out_href  = hr_d[LAT-1];

endmodule

// File: tb/tb_isp_csc_inv.sv
// tb/tb_isp_csc_inv.sv - self-checking bench for isp_csc_inv against an arithmetic reference model
// Honours ISP_CSC_INV_STUDIO_RANGE_EN the same way as the design.
module tb_isp_csc_inv;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } pix_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vsync = 1'b0, in_href = 1'b0;
  logic [7:0] in_y = '0, in_u = '0, in_v = '0;
  logic       out_vsync, out_href;
  logic [7:0] out_r, out_g, out_b;

  int          errors = 0;
  int          checks = 0;
  logic [25:0] obs, exp_v;
  pix_t        hist[$];

  always #5 pclk = ~pclk;

  isp_csc_inv dut (
    .pclk(pclk), .rst_n(rst_n),
    .in_vsync(in_vsync), .in_href(in_href),
    .in_y(in_y), .in_u(in_u), .in_v(in_v),
    .out_vsync(out_vsync), .out_href(out_href),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );

  function automatic int clip(int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic logic [25:0] model(pix_t p);
    int cb, cr, yl, r, g, b;
    cb = int'(p.u) - 128;
    cr = int'(p.v) - 128;
`ifdef ISP_CSC_INV_STUDIO_RANGE_EN
    yl = 298 * (int'(p.y) - 16);
    r  = (yl + 409 * cr + 128) >>> 8;
    g  = (yl - 100 * cb - 208 * cr + 128) >>> 8;
    b  = (yl + 516 * cb + 128) >>> 8;
`else
    yl = 256 * int'(p.y);
    r  = (yl + 359 * cr + 128) >>> 8;
    g  = (yl - 88 * cb - 183 * cr + 128) >>> 8;
    b  = (yl + 454 * cb + 128) >>> 8;
`endif
    if (!p.hr) begin
      r = 0; g = 0; b = 0;
    end
    return {p.vs, p.hr, 8'(clip(r)), 8'(clip(g)), 8'(clip(b))};
  endfunction

  function automatic pix_t rnd_pix(logic vs, logic hr);
    pix_t p;
    p.vs = vs;
    p.hr = hr;
    p.y  = 8'($urandom_range(1, 255));
    p.u  = 8'($urandom_range(1, 255));
    p.v  = 8'($urandom_range(1, 255));
    return p;
  endfunction

  function automatic pix_t mk_pix(logic vs, logic hr, int y, int u, int v);
    pix_t p;
    p.vs = vs; p.hr = hr; p.y = 8'(y); p.u = 8'(u); p.v = 8'(v);
    return p;
  endfunction

  // Sample outputs at the falling edge, retire the pixel driven 3 edges ago, drive the next one.
  task automatic step(input pix_t p);
    @(negedge pclk);
    obs   = {out_vsync, out_href, out_r, out_g, out_b};
    exp_v = model(hist.pop_front());
    in_vsync = p.vs; in_href = p.hr; in_y = p.y; in_u = p.u; in_v = p.v;
    hist.push_back(p);
  endtask

  task automatic prime_hist();
    hist.delete();
    repeat (3) hist.push_back(mk_pix(1'b0, 1'b0, 0, 0, 0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_href = 1'b1; in_vsync = 1'b1; in_y = 8'd200; in_u = 8'd10; in_v = 8'd250;
    repeat (2) begin
      @(negedge pclk);
      obs = {out_vsync, out_href, out_r, out_g, out_b};
      checks++;
      if (obs !== 26'd0) begin
        errors++;
        $display("FAIL reset_state: got %h expected %h", obs, 26'd0);
      end
    end
    in_href = 1'b0; in_vsync = 1'b0;
    rst_n = 1'b1;
    prime_hist();
  endtask

  task automatic test_grey();
    step(mk_pix(1'b0, 1'b1, 128, 128, 128));
    for (int i = 0; i < 3; i++) begin
      step(rnd_pix(1'b0, 1'b0));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL grey_model[%0d]: got %h expected %h", i, obs, exp_v);
      end
    end
    checks++;
    if (obs !== {1'b0, 1'b1, 8'd128, 8'd128, 8'd128}) begin
      errors++;
      $display("FAIL grey_const: got %h expected %h", obs, {1'b0, 1'b1, 8'd128, 8'd128, 8'd128});
    end
  endtask

`ifndef ISP_CSC_INV_STUDIO_RANGE_EN
  task automatic test_saturation();
    step(mk_pix(1'b0, 1'b1, 255, 128, 255));
    step(mk_pix(1'b0, 1'b1, 0, 0, 0));
    step(rnd_pix(1'b0, 1'b0));
    step(rnd_pix(1'b0, 1'b0));
    checks++;
    if (obs !== {1'b0, 1'b1, 8'd255, 8'd164, 8'd255}) begin
      errors++;
      $display("FAIL sat_high: got %h expected %h", obs, {1'b0, 1'b1, 8'd255, 8'd164, 8'd255});
    end
    step(rnd_pix(1'b0, 1'b0));
    checks++;
    if (obs !== {1'b0, 1'b1, 8'd0, 8'd136, 8'd0}) begin
      errors++;
      $display("FAIL sat_low: got %h expected %h", obs, {1'b0, 1'b1, 8'd0, 8'd136, 8'd0});
    end
  endtask
`else
  task automatic test_studio();
    step(mk_pix(1'b0, 1'b1, 16, 128, 128));
    step(mk_pix(1'b0, 1'b1, 235, 128, 128));
    step(mk_pix(1'b0, 1'b1, 0, 128, 128));
    step(rnd_pix(1'b0, 1'b0));
    checks++;
    if (obs !== {1'b0, 1'b1, 8'd0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL studio_black: got %h expected %h", obs, {1'b0, 1'b1, 24'd0});
    end
    step(rnd_pix(1'b0, 1'b0));
    checks++;
    if (obs !== {1'b0, 1'b1, 8'd255, 8'd255, 8'd255}) begin
      errors++;
      $display("FAIL studio_white: got %h expected %h", obs, {1'b0, 1'b1, 24'hffffff});
    end
    step(rnd_pix(1'b0, 1'b0));
    checks++;
    if (obs !== {1'b0, 1'b1, 8'd0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL studio_below_black: got %h expected %h", obs, {1'b0, 1'b1, 24'd0});
    end
  endtask
`endif

  task automatic test_sync_alignment();
    for (int line = 0; line < 2; line++) begin
      for (int k = 0; k < 7; k++) begin
        step(rnd_pix(line == 0 && k == 0, k < 4));
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL sync[%0d.%0d]: got %h expected %h", line, k, obs, exp_v);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(rnd_pix(1'b0, 1'b0));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sync_tail[%0d]: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    for (int k = 0; k < 6; k++) step(rnd_pix(k == 0, 1'b1));
    @(posedge pclk);
    #2 rst_n = 1'b0;
    #1 obs = {out_vsync, out_href, out_r, out_g, out_b};
    checks++;
    if (obs !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, 26'd0);
    end
    repeat (2) begin
      @(negedge pclk);
      {in_vsync, in_href, in_y, in_u, in_v} = rnd_pix(1'b1, 1'b1);
      obs = {out_vsync, out_href, out_r, out_g, out_b};
      checks++;
      if (obs !== 26'd0) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", obs, 26'd0);
      end
    end
    @(negedge pclk);
    {in_vsync, in_href, in_y, in_u, in_v} = rnd_pix(1'b0, 1'b0);
    rst_n = 1'b1;
    prime_hist();
    for (int k = 0; k < 10; k++) begin
      step(rnd_pix(1'b0, k >= 2 && k < 6));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 259; i++) begin
      if (i < 256)
        step(mk_pix(1'($urandom_range(0, 1)), 1'b1,
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255))));
      else
        step(rnd_pix(1'b0, 1'b0));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stream[%0d]: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_grey();
`ifndef ISP_CSC_INV_STUDIO_RANGE_EN
    test_saturation();
`else
    test_studio();
`endif
    test_sync_alignment();
    test_reset_mid_line();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
